upsample_seq: RTL and testbench

Sequencer for the 2x bilinear upsampling datapath. It accepts one input frame of N x N pixels (N = 4..64) over a valid/ready stream and drives the write enable and size select of the line-buffer stage. For every complete 2x2 neighbourhood it steps the interpolator through four output phases, emitting output coordinates with valid/ready backpressure. It sits between the input pixel source and the line buffer / interpolation datapath.

---
 rtl/upsample_seq.sv | 164 ++++++++++++++++
 tb/tb_upsample_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_seq.sv
// Sequencer for the 2x bilinear upsampler: loads an N x N frame, steps the
// interpolator through four output phases per complete 2x2 pixel window.
`timescale 1ns/1ps
module upsample_seq #(
  parameter int OUT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       size_sel,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             en_write_in,
  output logic [2:0]       size_upsample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_phase,
  output logic [OUT_W-1:0] out_row,
  output logic [OUT_W-1:0] out_col,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [5:0] r_r;
  logic [5:0] r_c;
  logic [5:0] r_wr;
  logic [5:0] r_wc;
  logic [1:0] r_ph;
  logic [2:0] r_size;
  logic       r_cfg_err;

  logic       w_size_ok;
  logic       w_start_ok;
  logic       w_accept;
  logic       w_fire;
  logic       w_window;
  logic       w_final;
  logic [5:0] w_last;
  logic [5:0] w_wr_m1;
  logic [5:0] w_wc_m1;

  // Largest coordinate of the latched frame size (N - 1).
  always_comb begin
    case (r_size)
      3'd0:    w_last = 6'd3;
      3'd1:    w_last = 6'd7;
      3'd2:    w_last = 6'd15;
      3'd3:    w_last = 6'd31;
      default: w_last = 6'd63;
    endcase
  end

  assign w_size_ok  = (size_sel <= 3'd4);
  assign w_start_ok = start & w_size_ok;
  assign w_accept   = (r_state == S_LOAD) & in_valid;
  assign w_fire     = (r_state == S_EMIT) & out_ready;
  // A window is complete once the accepted pixel has an up and a left neighbour.
  assign w_window   = (r_r != 6'd0) & (r_c != 6'd0);
  assign w_final    = (r_wr == w_last) & (r_wc == w_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_start_ok) w_state_nxt = S_LOAD;
        S_LOAD: if (w_accept && w_window) w_state_nxt = S_EMIT;
        S_EMIT: begin
          if (w_fire && (r_ph == 2'd3)) begin
            w_state_nxt = w_final ? S_DONE : S_LOAD;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_r       <= '0;
      r_c       <= '0;
      r_wr      <= '0;
      r_wc      <= '0;
      r_ph      <= '0;
      r_size    <= '0;
      r_cfg_err <= 1'b0;
    end else if (abort) begin
      r_r       <= '0;
      r_c       <= '0;
      r_ph      <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) & start & ~w_size_ok;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_size <= size_sel;
            r_r    <= '0;
            r_c    <= '0;
            r_ph   <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_wr <= r_r;
            r_wc <= r_c;
            if (r_c == w_last) begin
              r_c <= '0;
              r_r <= r_r + 6'd1;
            end else begin
              r_c <= r_c + 6'd1;
            end
            if (w_window) r_ph <= '0;
          end
        end
        S_EMIT: begin
          // Phase 3 wraps to 0; the next window entry clears it anyway.
          if (w_fire) r_ph <= r_ph + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_wr_m1 = r_wr - 6'd1;
  assign w_wc_m1 = r_wc - 6'd1;

  assign in_ready      = (r_state == S_LOAD);
  assign en_write_in   = in_valid & in_ready;
  assign out_valid     = (r_state == S_EMIT);
  assign busy          = (r_state == S_LOAD) | (r_state == S_EMIT);
  assign done          = (r_state == S_DONE);
  assign cfg_err       = r_cfg_err;
  assign size_upsample = r_size;
  assign out_phase     = out_valid ? r_ph : 2'd0;
  // Output pixel is 2*(w-1) plus the phase half bit, i.e. the half bit appended.
  assign out_row       = out_valid ? OUT_W'({w_wr_m1, r_ph[1]}) : '0;
  assign out_col       = out_valid ? OUT_W'({w_wc_m1, r_ph[0]}) : '0;

endmodule

// File: tb/tb_upsample_seq.sv
// Self-checking bench for upsample_seq: scoreboard of expected output phases
// built from the frame size, compared as the DUT emits them.
`timescale 1ns/1ps
module tb_upsample_seq;

  localparam int OUT_W = 7;

  typedef struct packed {
    logic [OUT_W-1:0] row;
    logic [OUT_W-1:0] col;
    logic [1:0]       ph;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       size_sel;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic             en_write_in;
  logic [2:0]       size_upsample;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_phase;
  logic [OUT_W-1:0] out_row;
  logic [OUT_W-1:0] out_col;
  logic             busy;
  logic             done;
  logic             cfg_err;

  int n_checks = 0;
  int n_fails  = 0;

  upsample_seq #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .size_sel(size_sel), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .en_write_in(en_write_in),
    .size_upsample(size_upsample), .out_valid(out_valid), .out_ready(out_ready),
    .out_phase(out_phase), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Runs one whole frame with in_valid held high; out_ready toggles when bp is set.
  task automatic run_frame(input int n, input logic [2:0] sel, input bit bp,
                           output int first_ov, output int done_at, output exp_t last);
    exp_t q[$];
    exp_t e;
    exp_t cur;
    exp_t prev;
    int   cyc;
    int   writes;
    int   phases;
    int   budget;
    bit   seen_done;
    bit   stalled;
    bit   irdy_bad;
    for (int wr = 1; wr < n; wr++) begin
      for (int wc = 1; wc < n; wc++) begin
        for (int p = 0; p < 4; p++) begin
          e.row = OUT_W'(2 * (wr - 1) + p / 2);
          e.col = OUT_W'(2 * (wc - 1) + p % 2);
          e.ph  = 2'(p);
          q.push_back(e);
        end
      end
    end
    first_ov  = -1;
    done_at   = -1;
    last      = '0;
    prev      = '0;
    writes    = 0;
    phases    = 0;
    seen_done = 0;
    stalled   = 0;
    irdy_bad  = 0;
    budget    = n * n + 8 * (n - 1) * (n - 1) + 50;
    @(negedge clk);
    size_sel  = sel;
    start     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc       = 0;
    while (!seen_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      cur.row = out_row;
      cur.col = out_col;
      cur.ph  = out_phase;
      if (done) begin
        seen_done = 1;
        done_at   = cyc;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fails++;
          $display("FAIL busy_at_done n=%0d: got %b expected 0", n, busy);
        end
      end
      if (out_valid) begin
        if (first_ov < 0) first_ov = cyc;
        if (in_ready !== 1'b0) irdy_bad = 1;
        if (stalled) begin
          n_checks++;
          if (cur !== prev) begin
            n_fails++;
            $display("FAIL stall_hold n=%0d cyc=%0d: got %h expected %h", n, cyc, cur, prev);
          end
        end
      end
      if (busy && size_upsample !== sel) begin
        n_checks++;
        n_fails++;
        $display("FAIL size_upsample n=%0d cyc=%0d: got %0d expected %0d", n, cyc, size_upsample, sel);
      end
      out_ready = bp ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (en_write_in) writes++;
      if (out_valid && out_ready) begin
        phases++;
        n_checks++;
        if (q.size() == 0) begin
          n_fails++;
          $display("FAIL extra_output n=%0d: got %h expected none", n, cur);
        end else begin
          e = q.pop_front();
          last = cur;
          if (cur !== e) begin
            n_fails++;
            $display("FAIL output n=%0d idx=%0d: got row=%0d col=%0d ph=%0d expected row=%0d col=%0d ph=%0d",
                     n, phases - 1, cur.row, cur.col, cur.ph, e.row, e.col, e.ph);
          end
        end
      end
      stalled = out_valid && !out_ready;
      prev    = cur;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (!seen_done) begin
      n_fails++;
      $display("FAIL done_timeout n=%0d: got no done expected done within %0d cycles", n, budget);
    end
    n_checks++;
    if (writes != n * n) begin
      n_fails++;
      $display("FAIL write_count n=%0d: got %0d expected %0d", n, writes, n * n);
    end
    n_checks++;
    if (phases != 4 * (n - 1) * (n - 1)) begin
      n_fails++;
      $display("FAIL phase_count n=%0d: got %0d expected %0d", n, phases, 4 * (n - 1) * (n - 1));
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_left n=%0d: got %0d pending expected 0", n, q.size());
    end
    n_checks++;
    if (irdy_bad) begin
      n_fails++;
      $display("FAIL in_ready_in_emit n=%0d: got 1 expected 0", n);
    end
    if (!bp) begin
      n_checks++;
      if (first_ov != n + 3) begin
        n_fails++;
        $display("FAIL first_valid n=%0d: got cycle %0d expected %0d", n, first_ov, n + 3);
      end
      n_checks++;
      if (done_at != n * n + 4 * (n - 1) * (n - 1) + 1) begin
        n_fails++;
        $display("FAIL done_cycle n=%0d: got %0d expected %0d", n, done_at,
                 n * n + 4 * (n - 1) * (n - 1) + 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] got;
    got = {10'd0, in_ready, en_write_in, size_upsample, out_valid, out_phase,
           out_row, out_col, busy, done, cfg_err};
    n_checks++;
    if (got !== 32'd0) begin
      n_fails++;
      $display("FAIL %s: got outputs %h expected 0", tag, got);
    end
  endtask

  task automatic check_last(input string tag, input exp_t got, input exp_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got row=%0d col=%0d ph=%0d expected row=%0d col=%0d ph=%0d",
               tag, got.row, got.col, got.ph, exp.row, exp.col, exp.ph);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; size_sel = 3'd0; abort = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_frame_4x4();
    int   fo, da;
    exp_t l;
    run_frame(4, 3'd0, 1'b0, fo, da, l);
    check_last("last_4x4", l, '{row: 7'd5, col: 7'd5, ph: 2'd3});
  endtask

  task automatic test_backpressure();
    int   fo, da;
    exp_t l;
    run_frame(4, 3'd0, 1'b1, fo, da, l);
    check_last("last_4x4_bp", l, '{row: 7'd5, col: 7'd5, ph: 2'd3});
  endtask

  task automatic test_invalid_size();
    int   fo, da;
    exp_t l;
    @(negedge clk);
    size_sel = 3'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || size_upsample !== 3'd0) begin
      n_fails++;
      $display("FAIL cfg_err_pulse: got cfg_err=%b busy=%b size=%0d expected 1 0 0",
               cfg_err, busy, size_upsample);
    end
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL cfg_err_clear: got cfg_err=%b busy=%b expected 0 0", cfg_err, busy);
    end
    run_frame(8, 3'd1, 1'b0, fo, da, l);
    check_last("last_8x8", l, '{row: 7'd13, col: 7'd13, ph: 2'd3});
  endtask

  task automatic test_reset_mid_frame();
    int   k;
    bit   got_done;
    int   fo, da;
    exp_t l;
    @(negedge clk);
    size_sel = 3'd2; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fails++;
      $display("FAIL reach_emit_16: got out_valid=0 expected 1 within 100 cycles");
    end
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_frame");
    got_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    n_checks++;
    if (got_done) begin
      n_fails++;
      $display("FAIL done_after_reset: got 1 expected 0");
    end
    run_frame(4, 3'd0, 1'b0, fo, da, l);
    check_last("last_after_reset", l, '{row: 7'd5, col: 7'd5, ph: 2'd3});
  endtask

  task automatic test_abort();
    int   cyc;
    bit   got_done;
    int   fo, da;
    exp_t l;
    @(negedge clk);
    size_sel = 3'd0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3);
      if (cyc == 3) size_sel = 3'd2;
    end
    start = 1'b0;
    n_checks++;
    if (cyc != 7 || out_row !== 7'd0 || out_col !== 7'd0 || out_phase !== 2'd0 || size_upsample !== 3'd0) begin
      n_fails++;
      $display("FAIL ignored_start: got cyc=%0d row=%0d col=%0d ph=%0d size=%0d expected 7 0 0 0 0",
               cyc, out_row, out_col, out_phase, size_upsample);
    end
    @(negedge clk);
    n_checks++;
    if (out_phase !== 2'd1 || out_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL phase_before_abort: got ph=%0d valid=%b expected 1 1", out_phase, out_valid);
    end
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_phase !== 2'd0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_idle: got valid=%b busy=%b in_ready=%b ph=%0d done=%b expected 0 0 0 0 0",
               out_valid, busy, in_ready, out_phase, done);
    end
    got_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) got_done = 1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got_done) begin
      n_fails++;
      $display("FAIL abort_stays_idle: got done/busy activity expected none");
    end
    run_frame(4, 3'd0, 1'b0, fo, da, l);
    check_last("last_after_abort", l, '{row: 7'd5, col: 7'd5, ph: 2'd3});
  endtask

  task automatic test_frame_64();
    int   fo, da;
    exp_t l;
    run_frame(64, 3'd4, 1'b0, fo, da, l);
    check_last("last_64x64", l, '{row: 7'd125, col: 7'd125, ph: 2'd3});
  endtask

  initial begin
    test_reset();
    test_frame_4x4();
    test_backpressure();
    test_invalid_size();
    test_reset_mid_frame();
    test_abort();
    test_frame_64();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
